signext_unit: RTL and testbench

Registered immediate sign-extender for the LEGv8 decode stage. It takes a 32-bit instruction word and recognises D-format loads/stores (LDUR, STUR) and CB-format CBZ. It extracts the signed immediate field and sign-extends it to 64 bits; any other encoding yields zero. The result is registered, giving one cycle of latency, with a valid strobe for the downstream ALU/branch logic.

---
 rtl/signext_unit.sv | 67 ++++++
 tb/tb_signext_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/signext_unit.sv
// rtl/signext_unit.sv - registered LEGv8 immediate sign-extender (LDUR/STUR/CBZ)
//
// Decodes a 32-bit instruction word and produces its sign-extended 64-bit
// immediate one clock after the word is strobed in.
//
// Ports:
//   clk    in   1   system clock, rising-edge
//   reset  in   1   asynchronous active-low reset
//   en     in   1   input strobe; samples `a` on the next rising edge
//   a      in  32   instruction word
//   y      out 64   registered sign-extended immediate (0 for unsupported words)
//   valid  out  1   high for the single cycle after a sampled `en`
//   hit    out  1   registered flag: sampled word was LDUR, STUR or CBZ

module signext_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] a,
    output logic [63:0] y,
    output logic        valid,
    output logic        hit
);

    localparam logic [10:0] OPC_LDUR = 11'b111_1100_0010;
    localparam logic [10:0] OPC_STUR = 11'b111_1100_0000;
    localparam logic [7:0]  OPC_CBZ  = 8'b1011_0100;

    logic [63:0] ext_d;
    logic        match_d;
    logic [63:0] y_q;
    logic        valid_q;
    logic        hit_q;

    // D-format and CB opcodes differ in a[31:29], so the cases never overlap.
    always_comb begin
        ext_d   = 64'h0;
        match_d = 1'b0;
        if (a[31:21] == OPC_LDUR || a[31:21] == OPC_STUR) begin
            ext_d   = {{55{a[20]}}, a[20:12]};
            match_d = 1'b1;
        end else if (a[31:24] == OPC_CBZ) begin
            ext_d   = {{45{a[23]}}, a[23:5]};
            match_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y_q     <= 64'h0;
            valid_q <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            valid_q <= en;
            // y and hit hold their last result while idle.
            if (en) begin
                y_q   <= ext_d;
                hit_q <= match_d;
            end
        end
    end

    assign y     = y_q;
    assign valid = valid_q;
    assign hit   = hit_q;

endmodule

// File: tb/tb_signext_unit.sv
// tb/tb_signext_unit.sv - scoreboard testbench for signext_unit

module tb_signext_unit;

    logic        clk;
    logic        reset;
    logic        en;
    logic [31:0] a;
    logic [63:0] y;
    logic        valid;
    logic        hit;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [63:0] y;
        logic        hit;
    } exp_t;

    exp_t sb_q[$];

    signext_unit dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .a     (a),
        .y     (y),
        .valid (valid),
        .hit   (hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the immediate as a signed integer, built with plain arithmetic.
    function automatic exp_t model(input logic [31:0] w);
        exp_t   r;
        longint field;
        longint val;
        int     bits;
        r.y   = 64'h0;
        r.hit = 1'b0;
        bits  = 0;
        field = 0;
        if ((w >> 21) == 32'h7C2 || (w >> 21) == 32'h7C0) begin
            bits  = 9;
            field = longint'((w >> 12) & 32'h1FF);
        end else if ((w >> 24) == 32'hB4) begin
            bits  = 19;
            field = longint'((w >> 5) & 32'h7FFFF);
        end
        if (bits != 0) begin
            val = field;
            if (field >= (longint'(1) << (bits - 1)))
                val = field - (longint'(1) << bits);
            r.y   = 64'(val);
            r.hit = 1'b1;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares on the falling edge, away from the sampling edge.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("spurious_valid", 64'(valid), 64'h0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("y", y, e.y);
                chk("hit", 64'(hit), 64'(e.hit));
            end
        end else if (sb_q.size() != 0) begin
            chk("missing_valid", 64'(valid), 64'h1);
            void'(sb_q.pop_front());
        end
    end

    // One cycle of stimulus: inputs change 1 time unit after the rising edge.
    task automatic issue(input logic e, input logic [31:0] w);
        en = e;
        a  = w;
        @(posedge clk);
        if (e && reset) sb_q.push_back(model(w));
        #1;
    endtask

    function automatic logic [31:0] rand_word(input int kind);
        logic [31:0] w;
        w = $urandom;
        case (kind)
            0: w = {11'h7C2, w[20:0]};
            1: w = {11'h7C0, w[20:0]};
            2: w = {8'hB4, w[23:0]};
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        reset = 1'b0;
        en    = 1'b1;
        a     = 32'hF85FF000;
        #1;
        chk("rst_y_async", y, 64'h0);
        // Held in reset with en high: nothing may load.
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, 32'hF85FF000);
            chk("rst_y", y, 64'h0);
            chk("rst_valid", 64'(valid), 64'h0);
            chk("rst_hit", 64'(hit), 64'h0);
        end
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            issue(1'b0, 32'hF85FF000);
            chk("post_rst_y", y, 64'h0);
            chk("post_rst_valid", 64'(valid), 64'h0);
        end

        // Directed cases; the monitor checks values, these check constants too.
        issue(1'b1, 32'hF85FF000);
        chk("ldur_neg", y, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(1'b1, 32'hF80FF000);
        chk("stur_pos", y, 64'h0000_0000_0000_00FF);
        issue(1'b1, 32'hF8100000);
        chk("stur_neg", y, 64'hFFFF_FFFF_FFFF_FF00);
        issue(1'b1, 32'hB4800000);
        chk("cbz_neg", y, 64'hFFFF_FFFF_FFFC_0000);
        issue(1'b1, 32'hB40000A0);
        chk("cbz_pos", y, 64'h5);
        chk("cbz_valid", 64'(valid), 64'h1);
        issue(1'b1, 32'h80000000);
        chk("non_insn_y", y, 64'h0);
        chk("non_insn_hit", 64'(hit), 64'h0);
        issue(1'b1, 32'h00000000);
        chk("zero_valid", 64'(valid), 64'h1);

        // Hold: LDUR then idle.
        issue(1'b1, 32'hF8408000);
        issue(1'b0, 32'hF80FF000);
        chk("hold_valid", 64'(valid), 64'h0);
        chk("hold_y", y, 64'h8);
        chk("hold_hit", 64'(hit), 64'h1);
        issue(1'b0, 32'h0);
        chk("hold_y2", y, 64'h8);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            issue(1'($urandom_range(0, 3) != 0), rand_word(int'($urandom_range(0, 3))));
        end

        // Asynchronous reset between edges mid-stream.
        issue(1'b1, 32'hF85FF000);
        en = 1'b1;
        a  = 32'hB4800000;
        #1;
        reset = 1'b0;
        sb_q.delete();
        #1;
        chk("async_y", y, 64'h0);
        chk("async_valid", 64'(valid), 64'h0);
        chk("async_hit", 64'(hit), 64'h0);
        #1;
        reset = 1'b1;
        en    = 1'b0;
        @(posedge clk);
        #1;
        chk("release_valid", 64'(valid), 64'h0);
        chk("release_y", y, 64'h0);
        issue(1'b1, 32'hF80FF000);
        chk("after_rst_y", y, 64'hFF);

        issue(1'b0, 32'h0);
        issue(1'b0, 32'h0);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
